// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  spi_pkg
//  Shared types and constants for the SPI burst controller.
//  Revision: 1.0
// ============================================================================
package spi_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_EXCH  = 2'b10,
      OP_EXCH2 = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_STORE = 3'd3,
      ST_TAIL  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] c_fill_byte = 8'hFF;

   function automatic logic [7:0] bit_reverse(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
//  spi_clk_gen
//  sclk divider: toggles sclk every CLK_DIV cycles while enabled and flags
//  whether each toggle is the leading or trailing edge of the bit period.
//  Revision: 1.0
// ============================================================================
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic load,
   input  logic cpol,
   output logic sclk,
   output logic lead,
   output logic trail
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             r_phase;
   logic             r_sclk;
   logic             w_wrap;

   assign w_wrap = en && (r_div == DIV_W'(CLK_DIV - 1));
   assign lead   = w_wrap && !r_phase;
   assign trail  = w_wrap &&  r_phase;
   assign sclk   = r_sclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div   <= '0;
         r_phase <= 1'b0;
         r_sclk  <= 1'b0;
      end else if (load) begin
         r_div   <= '0;
         r_phase <= 1'b0;
         r_sclk  <= cpol;
      end else if (en) begin
         if (w_wrap) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
            r_sclk  <= ~r_sclk;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end else begin
         // sclk simply holds: 16 toggles per byte always return it to cpol
         r_div   <= '0;
         r_phase <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_burst_controller.sv
`default_nettype none
// ============================================================================
//  spi_burst_controller
//  SPI master moving a burst of bytes between a local buffer and one of
//  NUM_CS slaves. Optional macro SPI_LSB_FIRST_EN adds the lsb_first input.
//  Revision: 1.0
// ============================================================================
module spi_burst_controller
   import spi_pkg::*;
#(
   parameter  int         MEM_SIZE  = 10,
   parameter  int         CLK_DIV   = 2,
   parameter  int         NUM_CS    = 1,
   parameter  logic [7:0] FILL_BYTE = c_fill_byte,
   localparam int         ADDR_W    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
   localparam int         CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [ADDR_W-1:0] size,
`ifdef SPI_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic [ADDR_W-1:0] address,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              wr,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t            r_state;
   op_t               r_op;
   logic              r_cpha;
   logic              r_lsb;
   logic [ADDR_W-1:0] r_size;
   logic [ADDR_W-1:0] r_address;
   logic [7:0]        r_tx;
   logic [7:0]        r_rx;
   logic [2:0]        r_bit_cnt;
   logic [DIV_W-1:0]  r_tail_cnt;
   logic [7:0]        r_data_out;
   logic              r_wr;
   logic              r_busy;
   logic              r_done;
   logic              r_mosi;
   logic [NUM_CS-1:0] r_cs_n;

   logic              w_lead;
   logic              w_trail;
   logic              w_shift;
   logic              w_sample;
   logic [ADDR_W-1:0] w_size_clamped;
   logic [7:0]        w_tx_raw;
   logic [7:0]        w_tx_byte;
   logic [7:0]        w_rx_final;
   logic [7:0]        w_rx_byte;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk   (clk),
      .rst   (rst),
      .en    (r_state == ST_SHIFT),
      .load  ((r_state == ST_IDLE) && start),
      .cpol  (cpol),
      .sclk  (sclk),
      .lead  (w_lead),
      .trail (w_trail)
   );

   // cpha selects which half of the bit period moves mosi and which samples miso
   assign w_shift  = r_cpha ? w_lead  : w_trail;
   assign w_sample = r_cpha ? w_trail : w_lead;

   assign w_size_clamped = (size > ADDR_W'(MEM_SIZE - 1)) ? ADDR_W'(MEM_SIZE - 1) : size;
   assign w_tx_raw       = (r_op == OP_READ) ? FILL_BYTE : data_in;
   assign w_tx_byte      = r_lsb ? bit_reverse(w_tx_raw) : w_tx_raw;
   // with cpha=1 the eighth sample lands on the same edge that ends the byte
   assign w_rx_final     = r_cpha ? {r_rx[6:0], miso} : r_rx;
   assign w_rx_byte      = r_lsb ? bit_reverse(w_rx_final) : w_rx_final;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_op       <= OP_READ;
         r_cpha     <= 1'b0;
         r_lsb      <= 1'b0;
         r_size     <= '0;
         r_address  <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_bit_cnt  <= '0;
         r_tail_cnt <= '0;
         r_data_out <= '0;
         r_wr       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mosi     <= 1'b1;
         r_cs_n     <= '1;
      end else begin
         r_wr   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op      <= op_t'(op);
                  r_cpha    <= cpha;
`ifdef SPI_LSB_FIRST_EN
                  r_lsb     <= lsb_first;
`else
                  r_lsb     <= 1'b0;
`endif
                  r_size    <= w_size_clamped;
                  r_address <= '0;
                  r_busy    <= 1'b1;
                  for (int i = 0; i < NUM_CS; i++) begin
                     r_cs_n[i] <= (cs_sel != CS_W'(i));
                  end
                  r_state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_tx      <= w_tx_byte;
               r_rx      <= '0;
               r_bit_cnt <= 3'd7;
               if (!r_cpha) r_mosi <= w_tx_byte[7];
               r_state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (w_shift) begin
                  // rotate rather than shift so a fill byte of all ones keeps mosi high
                  r_tx   <= {r_tx[6:0], r_tx[7]};
                  r_mosi <= r_cpha ? r_tx[7] : r_tx[6];
               end
               if (w_sample) r_rx <= {r_rx[6:0], miso};
               if (w_trail) begin
                  r_bit_cnt <= r_bit_cnt - 3'd1;
                  if (r_bit_cnt == 3'd0) begin
                     r_data_out <= w_rx_byte;
                     r_wr       <= (r_op != OP_WRITE);
                     r_state    <= ST_STORE;
                  end
               end
            end
            ST_STORE: begin
               if (r_address == r_size) begin
                  r_tail_cnt <= '0;
                  r_state    <= ST_TAIL;
               end else begin
                  r_address <= r_address + 1'b1;
                  r_state   <= ST_LOAD;
               end
            end
            ST_TAIL: begin
               if (r_tail_cnt == DIV_W'(CLK_DIV - 1)) begin
                  r_cs_n  <= '1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_tail_cnt <= r_tail_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_mosi  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign address  = r_address;
   assign data_out = r_data_out;
   assign wr       = r_wr;
   assign busy     = r_busy;
   assign done     = r_done;
   assign mosi     = r_mosi;
   assign cs_n     = r_cs_n;

endmodule
`default_nettype wire
